// File: rtl/base2log_pkg.sv
// Shared constants, fraction table and leading-one search for the base-2 log pipeline.
package base2log_pkg;

  localparam int unsigned DEF_INPUT_WIDTH  = 32;
  localparam int unsigned DEF_MANT_BITS    = 4;
  localparam int unsigned DEF_FRAC_BITS    = 3;
  localparam int unsigned DEF_OUTPUT_WIDTH = $clog2(DEF_INPUT_WIDTH) + DEF_FRAC_BITS;

  // Widest operand the leading-one search handles.
  localparam int unsigned LOD_MAX_WIDTH = 64;
  localparam int unsigned LOD_IDX_W     = $clog2(LOD_MAX_WIDTH);

  // One extra bit so the m=15 entry can carry a full unit into the integer part.
  typedef logic [DEF_FRAC_BITS:0] frac_t;

  // round(2^FRAC_BITS * log2(1 + m/2^MANT_BITS)) for m = 0..15
  localparam frac_t FRAC_LUT [2**DEF_MANT_BITS] = '{
    4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
    4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8
  };

  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [LOD_IDX_W-1:0] lead_one_pos(input logic [LOD_MAX_WIDTH-1:0] v);
    lead_one_pos = '0;
    for (int unsigned i = 0; i < LOD_MAX_WIDTH; i++) begin
      if (v[i]) lead_one_pos = LOD_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/base2log_if.sv
// Operand/result bundle between a producer and the base2log pipeline.
interface base2log_if #(
  parameter int unsigned INPUT_WIDTH  = base2log_pkg::DEF_INPUT_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = base2log_pkg::DEF_OUTPUT_WIDTH
);
  logic                    valid_i;
  logic [INPUT_WIDTH-1:0]  number_i;
  logic                    valid_o;
  logic [OUTPUT_WIDTH-1:0] log_o;

  modport master (output valid_i, number_i, input valid_o, log_o);
  modport slave  (input valid_i, number_i, output valid_o, log_o);
endinterface

// File: rtl/base2log_lod.sv
// Leading-one detector: highest set bit index plus an all-zero flag.
module base2log_lod
  import base2log_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0]         number,
  output logic [$clog2(INPUT_WIDTH)-1:0] index,
  output logic                           zero
);
  localparam int unsigned IDX_W = $clog2(INPUT_WIDTH);

  assign index = IDX_W'(lead_one_pos(LOD_MAX_WIDTH'(number)));
  assign zero  = ~|number;
endmodule

// File: rtl/base2log.sv
// Two-stage pipelined log2 of an unsigned integer, result in unsigned Q(e).FRAC_BITS.
module base2log
  import base2log_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int unsigned MANT_BITS    = DEF_MANT_BITS,
  parameter int unsigned FRAC_BITS    = DEF_FRAC_BITS,
  parameter int unsigned OUTPUT_WIDTH = $clog2(INPUT_WIDTH) + FRAC_BITS
) (
  input  logic     clk,
  input  logic     rst,
  base2log_if.slave bus
);
  localparam int unsigned E_W   = $clog2(INPUT_WIDTH);
  localparam int unsigned SUM_W = OUTPUT_WIDTH + 1;

  logic [E_W-1:0]         lod_e;
  logic                   lod_zero;
  logic [E_W-1:0]         shamt;
  logic [INPUT_WIDTH-1:0] norm;
  logic [MANT_BITS-1:0]   mant;

  logic                   s1_valid;
  logic [E_W-1:0]         s1_e;
  logic [MANT_BITS-1:0]   s1_m;
  logic                   s1_zero;

  frac_t                  frac;
  logic [SUM_W-1:0]       sum;
  logic [OUTPUT_WIDTH-1:0] log_next;

  logic                    out_valid;
  logic [OUTPUT_WIDTH-1:0] out_log;

  base2log_lod #(.INPUT_WIDTH(INPUT_WIDTH)) u_lod (
    .number (bus.number_i),
    .index  (lod_e),
    .zero   (lod_zero)
  );

  // Shifting the leading one to the MSB leaves the mantissa directly below it,
  // already left-aligned and zero-padded when few bits sit under the leading one.
  always_comb begin
    shamt = E_W'(INPUT_WIDTH - 1) - lod_e;
    norm  = bus.number_i << shamt;
    mant  = norm[INPUT_WIDTH-2 -: MANT_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_e     <= '0;
      s1_m     <= '0;
      s1_zero  <= 1'b0;
    end else begin
      s1_valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1_e    <= lod_e;
        s1_m    <= mant;
        s1_zero <= lod_zero;
      end
    end
  end

  always_comb begin
    frac = FRAC_LUT[s1_m];
    sum  = SUM_W'({s1_e, {FRAC_BITS{1'b0}}}) + SUM_W'(frac);
    if (s1_zero)
      log_next = '0;
    else if (sum[OUTPUT_WIDTH])
      log_next = '1;
    else
      log_next = sum[OUTPUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_log   <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) out_log <= log_next;
    end
  end

  assign bus.valid_o = out_valid;
  assign bus.log_o   = out_log;

endmodule

// File: tb/tb_base2log.sv
// Scoreboard bench for base2log: directed cases from the plan plus randomized traffic.
module tb_base2log;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  base2log_if #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(8)) bus ();

  base2log #(
    .INPUT_WIDTH  (32),
    .MANT_BITS    (4),
    .FRAC_BITS    (3),
    .OUTPUT_WIDTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] last_exp = 8'h00;
  bit         armed    = 1'b0;

  // floor(log2 n) plus a fraction from real-valued log2 of the truncated mantissa
  function automatic logic [7:0] ref_log2(input logic [31:0] n);
    longint unsigned x;
    int  e;
    int  m;
    int  f;
    int  r;
    real fr;
    if (n == 32'd0) return 8'h00;
    x = longint'(n);
    e = 0;
    while ((x >> (e + 1)) != 0) e++;
    m  = int'(((x << 4) >> e) & 64'd15);
    fr = 8.0 * $ln(1.0 + m / 16.0) / $ln(2.0);
    f  = $rtoi(fr + 0.5);
    r  = e * 8 + f;
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Edge bookkeeping: a reset edge discards everything in flight.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        last_exp = 8'h00;
        armed    = 1'b1;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          check("valid_o", 32'(bus.valid_o), 32'd1);
          check("log_o", 32'(bus.log_o), 32'(e.val));
          last_exp = e.val;
        end else begin
          check("valid_o idle", 32'(bus.valid_o), 32'd0);
          check("log_o hold", 32'(bus.log_o), 32'(last_exp));
        end
      end
    end
  end

  task automatic cycle(input bit r, input bit v, input logic [31:0] n, input logic [7:0] exp_val);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    bus.valid_i = v;
    bus.number_i = n;
    if (v) begin
      e.due = cyc + 2;
      e.val = exp_val;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] n, input logic [7:0] exp_val);
    cycle(1'b0, 1'b1, n, exp_val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, 8'h00);
  endtask

  initial begin
    logic [31:0] n;
    rst          = 1'b1;
    bus.valid_i  = 1'b1;
    bus.number_i = 32'h1234;
    repeat (2) @(posedge clk);
    idle(3);

    send(32'h1,        8'h00);
    send(32'h2,        8'h08);
    send(32'h100,      8'h40);
    send(32'h80000000, 8'hF8);
    idle(2);

    send(32'd3,        8'h0D);
    send(32'd1000,     8'h50);
    send(32'h18000,    8'h85);
    send(32'h0,        8'h00);
    send(32'hFFFFFFFF, 8'hFF);
    idle(3);

    send(32'd16, 8'h20);
    cycle(1'b0, 1'b0, 32'hDEAD_BEEF, 8'h00);
    send(32'd24, 8'h25);
    send(32'd7,  8'h16);
    idle(3);

    send(32'h0004_0000, 8'h90);
    cycle(1'b1, 1'b1, 32'h0000_0300, 8'h4D);
    idle(4);
    send(32'd5, ref_log2(32'd5));
    idle(3);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       n = 32'h0;
        1:       n = 32'hFFFFFFFF;
        2:       n = 32'h1 << $urandom_range(0, 31);
        default: n = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 49) == 0)
        cycle(1'b1, 1'($urandom_range(0, 1)), n, ref_log2(n));
      else if ($urandom_range(0, 3) == 0)
        cycle(1'b0, 1'b0, n, 8'h00);
      else
        send(n, ref_log2(n));
    end
    idle(4);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/base2log.md
Name: base2log

Overview:
- Pipelined fixed-point base-2 logarithm of an unsigned integer.
- Used by the mel filterbank to compress each 32-bit filter-bank energy sum into an 8-bit log-energy value.
- Output format is unsigned Q5.3: 5 integer bits (0..31) and 3 fractional bits.
- Fixed 2-cycle latency, one result per cycle, no backpressure.

Parameters:
- INPUT_WIDTH, 32: width of the unsigned input operand.
- MANT_BITS, 4: number of mantissa bits below the leading one used to index the fraction LUT.
- FRAC_BITS, 3: number of fractional bits in the result.
- OUTPUT_WIDTH, $clog2(INPUT_WIDTH)+FRAC_BITS (=8): result width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  number_i is valid this cycle.
- number_i  input  INPUT_WIDTH  unsigned operand.
- valid_o  output  1  log_o is valid this cycle.
- log_o  output  OUTPUT_WIDTH  round-ish log2(number_i) in Q5.3.

Behaviour:
- Reset: on a clk edge with rst=1, all pipeline valids clear; valid_o=0 and log_o=0x00 from the next cycle. Reset overrides any in-flight samples, which are discarded.
- Latency: a sample accepted with valid_i=1 at edge N appears with valid_o=1 after edge N+2.
  - valid_i=0 bubbles propagate as valid_o=0.
  - log_o holds its last value while valid_o=0.
- Stage 1, registered:
  - Leading-one detect gives e, the index of the highest set bit (0..INPUT_WIDTH-1).
  - Mantissa m is the MANT_BITS bits immediately below bit e, left-aligned.
  - If fewer than MANT_BITS bits exist below e, m is zero-padded on the right. For example, number_i=3 gives e=1, m=4'b1000.
  - A zero flag z is set when number_i==0.
- Stage 2, registered:
  - f = LUT[m], where LUT[m] = round(2^FRAC_BITS * log2(1 + m/2^MANT_BITS)).
  - Default table for m=0..15: 0,1,1,2,3,3,4,4,5,5,6,6,6,7,7,8.
  - result = (e << FRAC_BITS) + f, computed one bit wider than OUTPUT_WIDTH. An f of 8 carries into the integer part.
  - If the result exceeds 2^OUTPUT_WIDTH-1, saturate log_o to all ones (0xFF).
  - If z=1, log_o=0x00, the same as number_i=1. The consumer detects zero energy separately.
- Purely unsigned arithmetic, no signed interpretation of number_i.
- Valid back-to-back every cycle, and independent samples never interact.

Decomposition:
- Package base2log_pkg holds:
  - default width constants;
  - the fraction LUT as a constant array indexed by m;
  - a leading-one-position function (priority encoder from MSB).
- No sub-module is needed; the two pipeline stages sit in one module.
- If a separate unit is wanted, a leading_one_detector sub-module (INPUT_WIDTH in, $clog2(INPUT_WIDTH) index out, plus zero flag) is natural.

Test Plan:
- Reset and idle: assert rst for 2 cycles with valid_i=1 and number_i=0x1234 -> valid_o=0 and log_o=0x00 during reset and for 2 cycles after release.
- Powers of two: 1, 2, 0x100, 0x80000000 on consecutive cycles -> valid_o high 2 cycles later with log_o = 0x00, 0x08, 0x40, 0xF8 in order.
- Fraction and carry:
  - 3 -> 0x0D.
  - 1000 -> 0x50 (m=15 carries).
  - 0x18000 (1.5*2^16) -> 0x85.
- Zero and saturation: 0 -> 0x00; 0xFFFFFFFF -> 0xFF (carry from e=31 saturates).
- Streaming and bubbles: pattern valid_i = 1,0,1,1 with values 16, X, 24, 7 -> valid_o = 1,0,1,1 with log_o = 0x20, (held), 0x25, 0x16, each exactly 2 cycles later.
- Mid-stream reset: rst pulsed one cycle while two samples are in flight -> neither sample emerges and valid_o stays 0 until a new valid_i.
